// File: rtl/duty50_div.sv
// duty50_div: programmable clock divider with a 50% duty cycle for any divisor N >= 2.
// Even N needs only posedge logic. For odd N, a negedge copy of the high phase
// stretches the output by half a clk period. Divisor changes and stops wait for
// the current period to end, so the output never shows a runt pulse.
module duty50_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    output logic             out,
    output logic             tick,
    output logic             active,
    output logic             pend,
    output logic             err
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] div_r_nxt;
    logic             out_p;
    logic             out_p_nxt;
    logic             out_n;
    logic             tick_nxt;
    logic             active_nxt;
    logic             err_nxt;

    logic [WIDTH-1:0] last_cnt;     // count value of the final clk period: div_r-1
    logic [WIDTH:0]   cnt_inc;      // cnt+1, one bit wider so it cannot wrap
    logic [WIDTH:0]   half_div;     // floor(div_r/2) at the same width as cnt_inc
    logic             at_boundary;
    logic             div_ok;       // requested divisor is >= 2

    assign last_cnt    = div_r - {{(WIDTH-1){1'b0}}, 1'b1};
    assign cnt_inc     = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign half_div    = {2'b00, div_r[WIDTH-1:1]};
    assign at_boundary = (cnt == last_cnt);
    assign div_ok      = |div[WIDTH-1:1];

    // Next-state logic: idle/start, counting, and the period-boundary decision.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that skipped
        // one would make synthesis infer a latch to hold it.
        cnt_nxt    = cnt;
        div_r_nxt  = div_r;
        out_p_nxt  = out_p;
        tick_nxt   = 1'b0;
        active_nxt = active;
        err_nxt    = err;

        if (!active) begin
            out_p_nxt = 1'b0;
            if (en && div_ok) begin
                div_r_nxt  = div;
                cnt_nxt    = '0;
                out_p_nxt  = 1'b1;
                tick_nxt   = 1'b1;
                active_nxt = 1'b1;
                err_nxt    = 1'b0;
            end else begin
                // Refused start if en is high, otherwise a quiet idle clears the flag.
                err_nxt = en;
            end
        end else if (!at_boundary) begin
            cnt_nxt   = cnt_inc[WIDTH-1:0];
            out_p_nxt = (cnt_inc < half_div);
        end else if (en && div_ok) begin
            // Reload at the boundary: the new divisor takes effect cleanly here.
            div_r_nxt = div;
            cnt_nxt   = '0;
            out_p_nxt = 1'b1;
            tick_nxt  = 1'b1;
        end else begin
            active_nxt = 1'b0;
            out_p_nxt  = 1'b0;
            cnt_nxt    = '0;
            if (en) begin
                err_nxt = 1'b1;
            end
        end
    end

    // Posedge state register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            cnt    <= '0;
            div_r  <= '0;
            out_p  <= 1'b0;
            tick   <= 1'b0;
            active <= 1'b0;
            err    <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            div_r  <= div_r_nxt;
            out_p  <= out_p_nxt;
            tick   <= tick_nxt;
            active <= active_nxt;
            err    <= err_nxt;
        end
    end

    // Half-period delayed copy of the high phase, used to stretch odd divisors.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            out_n <= 1'b0;
        end else begin
            out_n <= out_p;
        end
    end

    // The output is a plain OR of two flops: rising edges come only from out_p (posedge),
    // and the extension is gated off for even divisors.
    assign out  = out_p | (div_r[0] & out_n);
    assign pend = active & (div != div_r);

endmodule

// File: tb/tb_duty50_div.sv
// tb_duty50_div: directed self-checking bench for duty50_div (WIDTH = 8).
// Outputs are sampled 1 ns after each posedge (first half of a clk period) and
// 1 ns after each negedge (second half), so both halves of the odd-N waveform are seen.
`timescale 1ns/1ps
module tb_duty50_div;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             en    = 1'b0;
    logic [WIDTH-1:0] div   = '0;
    logic             out;
    logic             tick;
    logic             active;
    logic             pend;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    duty50_div #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .div    (div),
        .out    (out),
        .tick   (tick),
        .active (active),
        .pend   (pend),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Watchdog: the directed sequence runs for a few thousand ns at most.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance to 1 ns after the next posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run whole periods of divisor n. Called when the next posedge starts or reloads a
    // period (cnt becomes 0). pattern holds 2n expected out values, MSB first:
    // first half then second half of each clk period.
    task automatic run_halves(input string tag, input int n, input logic [31:0] pattern,
                              input int periods);
        for (int p = 0; p < periods; p++) begin
            for (int k = 0; k < n; k++) begin
                step();
                check($sformatf("%s p%0d k%0d out_a", tag, p, k), out, pattern[2*n-1-2*k]);
                check($sformatf("%s p%0d k%0d tick", tag, p, k), tick, (k == 0));
                check($sformatf("%s p%0d k%0d active", tag, p, k), active, 1'b1);
                check($sformatf("%s p%0d k%0d pend", tag, p, k), pend, 1'b0);
                @(negedge clk);
                #1;
                check($sformatf("%s p%0d k%0d out_b", tag, p, k), out, pattern[2*n-2-2*k]);
            end
        end
    endtask

    initial begin
        // ---- Reset state, asserted before any clock edge ----
        #1 reset = 1'b1;
        #2;
        check("rst out", out, 1'b0);
        check("rst tick", tick, 1'b0);
        check("rst active", active, 1'b0);
        check("rst pend", pend, 1'b0);
        check("rst err", err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---- Idle with en low ----
        step();
        check("idle out", out, 1'b0);
        check("idle active", active, 1'b0);
        check("idle err", err, 1'b0);

        // ---- Even duty, N=4: 2 high / 2 low ----
        en  = 1'b1;
        div = 8'd4;
        run_halves("n4", 4, 32'b11110000, 2);

        // ---- Change to N=5 right at the boundary cycle, then odd duty 2.5 / 2.5 ----
        div = 8'd5;
        #1;
        check("n4->5 pend", pend, 1'b1);
        run_halves("n5", 5, 32'b1111100000, 2);

        // ---- Divisor change 5->6 at cnt=1: old period completes with N=5 ----
        step();
        check("chg k0 tick", tick, 1'b1);
        check("chg k0 out", out, 1'b1);
        step();
        check("chg k1 out", out, 1'b1);
        div = 8'd6;
        #1;
        check("chg k1 pend", pend, 1'b1);
        step();
        check("chg k2 out_a", out, 1'b1);
        check("chg k2 pend", pend, 1'b1);
        check("chg k2 tick", tick, 1'b0);
        @(negedge clk);
        #1;
        check("chg k2 out_b", out, 1'b0);
        step();
        check("chg k3 out", out, 1'b0);
        check("chg k3 pend", pend, 1'b1);
        step();
        check("chg k4 out", out, 1'b0);
        check("chg k4 pend", pend, 1'b1);
        check("chg k4 tick", tick, 1'b0);
        run_halves("n6", 6, 32'b111111000000, 2);

        // ---- Disable at cnt=1 with N=8: period completes 4/4, then stop ----
        div = 8'd8;
        step();
        check("dis k0 tick", tick, 1'b1);
        step();
        check("dis k1 out", out, 1'b1);
        en = 1'b0;
        for (int c = 2; c < 8; c++) begin
            step();
            check($sformatf("dis k%0d out", c), out, (c < 4));
            check($sformatf("dis k%0d active", c), active, 1'b1);
        end
        step();
        check("dis stop active", active, 1'b0);
        check("dis stop out", out, 1'b0);
        check("dis stop tick", tick, 1'b0);
        check("dis stop err", err, 1'b0);
        @(negedge clk);
        #1;
        check("dis stop out_b", out, 1'b0);
        step();
        check("dis idle out", out, 1'b0);
        check("dis idle active", active, 1'b0);

        // ---- Invalid divisor from idle: refused, err raised ----
        en  = 1'b1;
        div = 8'd1;
        step();
        check("inv err", err, 1'b1);
        check("inv active", active, 1'b0);
        check("inv out", out, 1'b0);
        check("inv pend", pend, 1'b0);
        check("inv tick", tick, 1'b0);

        // ---- Then N=3 starts, err clears, 1.5 / 1.5 ----
        div = 8'd3;
        run_halves("n3", 3, 32'b111000, 2);
        check("n3 err", err, 1'b0);

        // ---- Boundary stop with en high and div<2 raises err ----
        div = 8'd0;
        step();
        check("bstop active", active, 1'b0);
        check("bstop err", err, 1'b1);
        check("bstop out", out, 1'b0);

        // ---- Maximum divisor 255: high 127.5 clk, period 255 clk, cnt wraps ----
        div = 8'd255;
        step();
        check("max start tick", tick, 1'b1);
        check("max start err", err, 1'b0);
        check("max start out", out, 1'b1);
        for (int i = 1; i < 255; i++) begin
            step();
            if (tick !== 1'b0) begin
                check($sformatf("max k%0d tick", i), tick, 1'b0);
            end
            if (i == 126) begin
                check("max k126 out", out, 1'b1);
            end
            if (i == 127) begin
                check("max k127 out_a", out, 1'b1);
                @(negedge clk);
                #1;
                check("max k127 out_b", out, 1'b0);
            end
            if (i == 254) begin
                check("max k254 out", out, 1'b0);
                check("max k254 active", active, 1'b1);
            end
        end
        step();
        check("max wrap tick", tick, 1'b1);
        check("max wrap out", out, 1'b1);
        step();
        check("max k1 tick", tick, 1'b0);
        step();

        // ---- Reset mid-high: out drops immediately, no period completion ----
        check("pre-rst out", out, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid rst out", out, 1'b0);
        check("mid rst tick", tick, 1'b0);
        check("mid rst active", active, 1'b0);
        check("mid rst pend", pend, 1'b0);
        check("mid rst err", err, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // ---- First posedge after reset follows the start rule ----
        step();
        check("post rst tick", tick, 1'b1);
        check("post rst active", active, 1'b1);
        check("post rst out", out, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
